interface_input: RTL
====================

Name: interface_input

Overview:
- Front-end adapter of the CORDIC core, the mirror of the output interface.
- Accepts external samples in INPUT fixed-point format through a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Converts each sample to the internal iteration-word format and, in arctan (vectoring) mode, folds negative x into the right half-plane.
- Presents each sample to iteration stage 0 together with the flip flag that the output interface later uses to restore the sign of x.

Parameters:
- INPUT_WIDTH, 16, external sample width.
- INPUT_INT_WIDTH, 7, integer bits of the input format (sign excluded).
- INPUT_FRAC_WIDTH, 8, fraction bits of the input format.
- ITERATION_WORD_WIDTH, 32, internal word width.
- ITERATION_WORD_INT_WIDTH, 12, internal integer bits (sign included).
- ITERATION_WORD_FRAC_WIDTH, 20, internal fraction bits.
- FLIP_FLAG_WIDTH, 1, flip flag width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- degree_in  in  INPUT_WIDTH  signed rotation angle (ignored in arctan mode).
- x_in  in  INPUT_WIDTH  signed x.
- y_in  in  INPUT_WIDTH  signed y.
- arctan_en_in  in  1  1 = vectoring/arctan mode, 0 = rotation mode.
- valid_in  in  1  sample present.
- ready_in  out  1  block can accept a sample this cycle.
- core_ready  in  1  stage 0 accepts the presented sample.
- degree_core  out  ITERATION_WORD_WIDTH  converted angle.
- x_core  out  ITERATION_WORD_WIDTH  converted, possibly negated, x.
- y_core  out  ITERATION_WORD_WIDTH  converted y.
- flip_core  out  FLIP_FLAG_WIDTH  x was negated at input.
- arctan_en_core  out  1  mode, forwarded.
- valid_core  out  1  output register holds a sample.

Behaviour:
- Reset: on clk edge with rst=1, the following are all 0 and the skid buffer is emptied:
  - valid_core, flip_core, arctan_en_core
  - degree_core, x_core, y_core
  - ready_in is 1 during the cycle following reset.
- Handshake:
  - Input transfer when valid_in && ready_in.
  - Output transfer when valid_core && core_ready.
  - valid_core and its payload hold steady until transferred.
  - ready_in is a register output: ready_in = !skid_full.
- Skid buffer:
  - Output register plus one skid register.
  - Output register loads when !valid_core || core_ready.
  - Load source is the skid register if occupied, else the incoming sample.
  - Incoming sample goes to the skid register when the output register cannot load.
  - Simultaneous input and output transfer with skid empty: pass-through, no bubble.
  - Skid full: ready_in=0 until the skid drains.
  - Sustained throughput is 1 sample/cycle when core_ready=1.
- Latency: valid_in accepted at edge N gives valid_core=1 after edge N (1 cycle) when unstalled.
- Format conversion (done before registering; applies to x, y, degree):
  - Sign-extend to ITERATION_WORD_WIDTH.
  - Then arithmetic left shift by ITERATION_WORD_FRAC_WIDTH-INPUT_FRAC_WIDTH (12 at defaults).
  - A compile-time check fails elaboration if the shift is negative or the integer field would truncate.
- Fold rule:
  - arctan_en_in=1 and x_in<0: x_core = -(converted x) computed at ITERATION_WORD_WIDTH, flip_core=1.
  - Negating the most negative input (0x8000) is therefore exact, no saturation.
  - x_in=0 or positive, or rotation mode: no negation, flip_core=0.
  - y and degree are never negated.
  - In arctan mode degree_core = 0.
- Boundary conditions:
  - rst asserted mid-stream discards both buffered samples.
  - No output transfer is reported for discarded samples.
  - valid_in ignored while ready_in=0.
  - core_ready while valid_core=0 has no effect.

Decomposition:
- Shared package cordic_pkg: width/format constants, the conversion shift amount, the flip flag encoding (1 = negated).
- The output interface imports the same package.
- One sub-module, skid_buffer, parameterised by payload width.
- Payload packing and conversion stay in interface_input.

Test Plan:
- Reset then idle → ready_in=1, valid_core=0, all outputs 0.
- Rotation sample x=0x0100, y=0x0080, degree=0x1E00, arctan_en=0, core_ready=1 → next cycle:
  - x_core=0x00100000, y_core=0x00080000, degree_core=0x01E00000
  - flip_core=0, valid_core=1.
- Arctan sample x=0xFF00 (-1.0), y=0x0100 → x_core=0x00100000, y_core=0x00100000, degree_core=0, flip_core=1.
- Arctan x=0x8000 → x_core=0x08000000, flip_core=1 (no overflow); x=0x0000 → flip_core=0.
- Back-pressure: core_ready=0 while 3 samples are offered back-to-back:
  - First sample held on outputs, second sample in the skid.
  - ready_in=0 from the cycle after the second acceptance; third sample held off.
  - Raise core_ray core_ready → samples emerge in order, none lost or duplicated.
- rst pulsed with both registers full → valid_core=0 next cycle, ready_in=1, no stale sample emitted afterwards.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared formats and encodings for the CORDIC input and output interfaces.
package cordic_pkg;

  localparam int INPUT_WIDTH               = 16;
  localparam int INPUT_INT_WIDTH           = 7;
  localparam int INPUT_FRAC_WIDTH          = 8;
  localparam int ITERATION_WORD_WIDTH      = 32;
  localparam int ITERATION_WORD_INT_WIDTH  = 12;
  localparam int ITERATION_WORD_FRAC_WIDTH = 20;
  localparam int FLIP_FLAG_WIDTH           = 1;

  // Left shift that aligns the input binary point with the iteration word.
  localparam int CONV_SHIFT = ITERATION_WORD_FRAC_WIDTH - INPUT_FRAC_WIDTH;

  // Flip flag encoding: 1 means x was negated on the way in.
  localparam logic [FLIP_FLAG_WIDTH-1:0] FLIP_NONE    = '0;
  localparam logic [FLIP_FLAG_WIDTH-1:0] FLIP_NEGATED = FLIP_FLAG_WIDTH'(1);

  typedef struct packed {
    logic [ITERATION_WORD_WIDTH-1:0] degree;
    logic [ITERATION_WORD_WIDTH-1:0] x;
    logic [ITERATION_WORD_WIDTH-1:0] y;
    logic [FLIP_FLAG_WIDTH-1:0]      flip;
    logic                            arctan_en;
  } core_payload_t;

  // Sign-extend an input sample and move its binary point to the internal position.
  function automatic logic [ITERATION_WORD_WIDTH-1:0] to_iter_word(
    input logic [INPUT_WIDTH-1:0] v
  );
    logic signed [ITERATION_WORD_WIDTH-1:0] ext;
    ext = signed'({{(ITERATION_WORD_WIDTH-INPUT_WIDTH){v[INPUT_WIDTH-1]}}, v});
    return ext <<< CONV_SHIFT;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: an output register plus one skid register.
// in_ready is registered (it is simply "skid empty") so the upstream ready path
// carries no combinational dependence on out_ready.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             in_fire;
  logic             load_out;

  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign in_fire   = in_valid && !skid_valid_q;
  assign load_out  = !out_valid_q || out_ready;

  // Next-state: refill the output register from the skid first, else from the input;
  // park the input in the skid when the output register is stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (load_out) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_data_d = in_data;
        end
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // State registers with synchronous reset; reset also clears payloads so outputs read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/interface_input.sv
// CORDIC front-end: converts input samples to the iteration-word format, folds
// negative x into the right half-plane in arctan mode, and buffers toward stage 0.
module interface_input
  import cordic_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [INPUT_WIDTH-1:0]          degree_in,
  input  logic [INPUT_WIDTH-1:0]          x_in,
  input  logic [INPUT_WIDTH-1:0]          y_in,
  input  logic                            arctan_en_in,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  logic                            core_ready,
  output logic [ITERATION_WORD_WIDTH-1:0] degree_core,
  output logic [ITERATION_WORD_WIDTH-1:0] x_core,
  output logic [ITERATION_WORD_WIDTH-1:0] y_core,
  output logic [FLIP_FLAG_WIDTH-1:0]      flip_core,
  output logic                            arctan_en_core,
  output logic                            valid_core
);

  // Reject format combinations that would need a right shift or lose integer bits.
  if (CONV_SHIFT < 0) begin : g_bad_shift
    $error("interface_input: iteration word has fewer fraction bits than the input");
  end
  if (INPUT_INT_WIDTH + 1 > ITERATION_WORD_INT_WIDTH) begin : g_bad_int
    $error("interface_input: iteration word integer field too narrow for input");
  end
  if (INPUT_WIDTH != 1 + INPUT_INT_WIDTH + INPUT_FRAC_WIDTH) begin : g_bad_in_fmt
    $error("interface_input: input format fields do not add up to INPUT_WIDTH");
  end

  core_payload_t in_payload;
  core_payload_t out_payload;
  logic [ITERATION_WORD_WIDTH-1:0] x_conv;
  logic                            do_fold;

  assign x_conv  = to_iter_word(x_in);
  assign do_fold = arctan_en_in && x_in[INPUT_WIDTH-1];

  // Pack the converted sample; negation is done at full word width so 0x8000 folds exactly.
  always_comb begin
    in_payload           = '0;
    in_payload.arctan_en = arctan_en_in;
    in_payload.y         = to_iter_word(y_in);
    in_payload.degree    = arctan_en_in ? '0 : to_iter_word(degree_in);
    in_payload.x         = do_fold ? (~x_conv + 1'b1) : x_conv;
    in_payload.flip      = do_fold ? FLIP_NEGATED : FLIP_NONE;
  end

  skid_buffer #(
    .WIDTH($bits(core_payload_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_payload),
    .in_valid  (valid_in),
    .in_ready  (ready_in),
    .out_data  (out_payload),
    .out_valid (valid_core),
    .out_ready (core_ready)
  );

  assign degree_core    = out_payload.degree;
  assign x_core         = out_payload.x;
  assign y_core         = out_payload.y;
  assign flip_core      = out_payload.flip;
  assign arctan_en_core = out_payload.arctan_en;

endmodule
